// File: rtl/cpu_hs_sender.sv
// CPU-side four-phase send/ack transmitter with a DEPTH-word push FIFO.
// Define HS_TIMEOUT_EN to abort a stalled handshake phase after TIMEOUT_CYC.
module cpu_hs_sender #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk2,
  input  logic              rst2,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic [DATA_W-1:0] dado,
  output logic              send,
  input  logic              ack,
  output logic              busy,
  output logic [CNT_W-1:0]  sent_count,
  output logic              timeout_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND     = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic              empty;
  logic              push;
  logic              pop;
  logic              done;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign push  = wr_en && !full;
  assign busy  = !empty || (state != IDLE);

  always_ff @(posedge clk2) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk2) begin
    if (!rst2) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

`ifdef HS_TIMEOUT_EN
  localparam int PW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW-1:0] TMO_LAST = PW'(TIMEOUT_CYC - 1);

  logic [PW-1:0] phase;
  logic          tmo;
  logic          tmo_hit;
  logic          err_q;

  assign tmo         = (phase == TMO_LAST);
  assign timeout_err = err_q;

  // Phase age restarts on every state entry.
  always_ff @(posedge clk2) begin
    if (!rst2) begin
      phase <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE || state_nx != state)
        phase <= '0;
      else
        phase <= phase + 1'b1;
      if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  // Keeps TIMEOUT_CYC referenced when the timeout is not built.
  assign timeout_err = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    done     = 1'b0;
`ifdef HS_TIMEOUT_EN
    tmo_hit  = 1'b0;
`endif
    unique case (1'b1)
      (state == IDLE): begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = SEND;
        end
      end
      (state == SEND): begin
        if (ack) begin
          done     = 1'b1;
          state_nx = WAIT_REL;
        end
`ifdef HS_TIMEOUT_EN
        else if (tmo) begin
          tmo_hit  = 1'b1;
          state_nx = IDLE;
        end
`endif
      end
      (state == WAIT_REL): begin
        if (!ack) begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = SEND;
          end else begin
            state_nx = IDLE;
          end
        end
`ifdef HS_TIMEOUT_EN
        else if (tmo) begin
          tmo_hit  = 1'b1;
          state_nx = IDLE;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk2) begin
    if (!rst2) begin
      state      <= IDLE;
      dado       <= '0;
      send       <= 1'b0;
      sent_count <= '0;
    end else begin
      state <= state_nx;
      send  <= (state_nx == SEND);
      if (pop)  dado       <= mem[rd_ptr];
      if (done) sent_count <= sent_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_hs_sender.sv
// Randomised bench for cpu_hs_sender against a queue-based handshake model.
// Timeout expectations follow HS_TIMEOUT_EN when it is defined.
module tb_cpu_hs_sender;

  localparam int DW     = 8;
  localparam int DEPTH  = 4;
  localparam int CW     = 8;
  localparam int TO_CYC = 16;
`ifdef HS_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic          clk2 = 1'b0;
  logic          rst2 = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          ack = 1'b0;
  logic          full;
  logic [DW-1:0] dado;
  logic          send;
  logic          busy;
  logic [CW-1:0] sent_count;
  logic          timeout_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk2 = ~clk2;

  cpu_hs_sender #(
    .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk2(clk2), .rst2(rst2), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .dado(dado), .send(send), .ack(ack), .busy(busy),
    .sent_count(sent_count), .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue FIFO, in-flight / releasing flags, phase age.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dado = '0;
  logic [CW-1:0] m_cnt = '0;
  logic [DW-1:0] wd;
  bit m_send, m_rel, m_err, started, had, pu, ps, pr;
  int m_age;

  always @(posedge clk2) begin
    if (!rst2) begin
      q.delete();
      m_send = 1'b0; m_rel = 1'b0; m_err = 1'b0;
      m_dado = '0; m_cnt = '0; m_age = 0;
      started = 1'b1;
    end else if (started) begin
      had = (q.size() != 0);
      pu  = wr_en && (q.size() < DEPTH);
      wd  = wr_data;
      ps  = m_send;
      pr  = m_rel;
      if (m_send) begin
        if (ack) begin
          m_send = 1'b0; m_rel = 1'b1; m_cnt++;
        end else if (TMO_ON && m_age == TO_CYC - 1) begin
          m_send = 1'b0; m_err = 1'b1;
        end
      end else if (m_rel) begin
        if (!ack) begin
          m_rel = 1'b0;
          if (had) begin m_dado = q.pop_front(); m_send = 1'b1; end
        end else if (TMO_ON && m_age == TO_CYC - 1) begin
          m_rel = 1'b0; m_err = 1'b1;
        end
      end else if (had) begin
        m_dado = q.pop_front(); m_send = 1'b1;
      end
      if ((m_send || m_rel) && m_send == ps && m_rel == pr) m_age++;
      else m_age = 0;
      if (pu) q.push_back(wd);
    end
  end

  always @(negedge clk2) begin
    if (started) begin
      chk("send", 32'(send), 32'(m_send));
      chk("dado", 32'(dado), 32'(m_dado));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("busy", 32'(busy), 32'(q.size() != 0 || m_send || m_rel));
      chk("sent_count", 32'(sent_count), 32'(m_cnt));
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
    end
  end

  logic [DW-1:0] seen[$];
  bit prev_send = 1'b0;
  always @(negedge clk2) begin
    if (send === 1'b1 && !prev_send) seen.push_back(dado);
    prev_send = (send === 1'b1);
  end

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  task automatic handshake_one(input int dly);
    for (int k = 0; k < 50; k++) begin
      if (send === 1'b1) break;
      step();
    end
    chk("hs_send_rise", 32'(send), 32'd1);
    repeat (dly) step();
    ack = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (send === 1'b0) break;
      step();
    end
    chk("hs_send_fall", 32'(send), 32'd0);
    step();
    ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held with a push strobe active.
    rst2 = 1'b0; wr_en = 1'b1; wr_data = 8'h5A;
    repeat (3) @(posedge clk2);
    #1 rst2 = 1'b1; wr_en = 1'b0;
    @(negedge clk2);
    chk("t1_send", 32'(send), 32'd0);
    chk("t1_dado", 32'(dado), 32'd0);
    chk("t1_full", 32'(full), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_cnt", 32'(sent_count), 32'd0);
    step();
    @(negedge clk2);
    chk("t1_noq", 32'(busy), 32'd0);

    // Single word with a slow peripheral.
    step();
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    @(negedge clk2);
    chk("t2_send_e0", 32'(send), 32'd0);
    step();
    @(negedge clk2);
    chk("t2_send_e1", 32'(send), 32'd1);
    chk("t2_dado", 32'(dado), 32'hA5);
    handshake_one(2);
    step(); step();
    @(negedge clk2);
    chk("t2_cnt", 32'(sent_count), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_dado_hold", 32'(dado), 32'hA5);

    // Five pushes against a stalled peripheral fill the FIFO.
    seen.delete();
    step();
    for (int k = 1; k <= 5; k++) begin
      wr_en = 1'b1; wr_data = DW'(k);
      step();
    end
    wr_en = 1'b0;
    @(negedge clk2);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_dado", 32'(dado), 32'h01);
    repeat (5) handshake_one(0);
    step(); step();
    @(negedge clk2);
    chk("t3_nwords", 32'(seen.size()), 32'd5);
    for (int k = 0; k < 5 && k < seen.size(); k++)
      chk("t3_order", 32'(seen[k]), 32'(k + 1));
    chk("t3_cnt", 32'(sent_count), 32'd6);
    chk("t3_busy", 32'(busy), 32'd0);

    // ack pulse while idle and empty.
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    @(negedge clk2);
    chk("t4_send", 32'(send), 32'd0);
    chk("t4_cnt", 32'(sent_count), 32'd6);
    chk("t4_busy", 32'(busy), 32'd0);

    // Peripheral never answers.
    step();
    wr_en = 1'b1; wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    repeat (200) step();
    @(negedge clk2);
    chk("t5_send", 32'(send), 32'(!TMO_ON));
    chk("t5_err", 32'(timeout_err), 32'(TMO_ON));
    chk("t5_cnt", 32'(sent_count), 32'd6);
`ifdef HS_TIMEOUT_EN
    step();
    wr_en = 1'b1; wr_data = 8'hC3;
    step();
    wr_en = 1'b0;
`endif
    handshake_one(1);
    step(); step();
    @(negedge clk2);
    chk("t5_cnt_after", 32'(sent_count), 32'd7);

    // Reset during WAIT_REL with two words queued.
    step();
    wr_en = 1'b1; wr_data = 8'h11;
    step();
    wr_data = 8'h22;
    step();
    wr_data = 8'h33;
    step();
    wr_en = 1'b0; ack = 1'b1;
    step(); step();
    @(negedge clk2);
    chk("t6_pre_busy", 32'(busy), 32'd1);
    chk("t6_pre_send", 32'(send), 32'd0);
    step();
    rst2 = 1'b0;
    step();
    rst2 = 1'b1;
    @(negedge clk2);
    chk("t6_send", 32'(send), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_full", 32'(full), 32'd0);
    chk("t6_cnt", 32'(sent_count), 32'd0);
    step();
    for (int k = 0; k < 6; k++) begin
      ack = ~ack;
      step();
    end
    ack = 1'b0;
    @(negedge clk2);
    chk("t6_ack_ign_send", 32'(send), 32'd0);
    chk("t6_ack_ign_busy", 32'(busy), 32'd0);

    // Random traffic with occasional reset.
    step();
    repeat (3000) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = DW'($urandom);
      ack     = 1'($urandom_range(0, 1));
      rst2    = ($urandom_range(0, 399) != 0);
      step();
    end
    rst2 = 1'b1; wr_en = 1'b0; ack = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
